// File: rtl/fast_square_step_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fast_square_step_accumulator: per-step I/Q window integrator, tagged     |
// | results on valid/ready.                              Rev 1.0             |
// +--------------------------------------------------------------------------+
module fast_square_step_accumulator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int STEP_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_q,
  input  logic                    sample_strobe,
  input  logic                    rx_record,
  input  logic                    rx_next,
  input  logic                    rx_reset,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [STEP_WIDTH-1:0]   result_step,
  output logic [ACC_WIDTH-1:0]    result_sum_i,
  output logic [ACC_WIDTH-1:0]    result_sum_q,
  output logic [15:0]             result_count,
  output logic                    result_sat,
  output logic [7:0]              drop_count
);

  localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam int                   c_ext     = ACC_WIDTH + 1 - SAMPLE_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                  r_state;
  logic [STEP_WIDTH-1:0]   r_step_idx;
  logic [STEP_WIDTH-1:0]   r_window_step;
  logic [ACC_WIDTH-1:0]    r_acc_i;
  logic [ACC_WIDTH-1:0]    r_acc_q;
  logic [15:0]             r_cnt;
  logic                    r_sat_flag;
  logic                    r_result_valid;
  logic [STEP_WIDTH-1:0]   r_result_step;
  logic [ACC_WIDTH-1:0]    r_result_sum_i;
  logic [ACC_WIDTH-1:0]    r_result_sum_q;
  logic [15:0]             r_result_count;
  logic                    r_result_sat;
  logic [7:0]              r_drop_count;

  logic [ACC_WIDTH:0]      w_sum_i_ext;
  logic [ACC_WIDTH:0]      w_sum_q_ext;
  logic                    w_ovf_i;
  logic                    w_ovf_q;
  logic [ACC_WIDTH-1:0]    w_acc_i_next;
  logic [ACC_WIDTH-1:0]    w_acc_q_next;
  logic [15:0]             w_cnt_next;
  logic                    w_accept;

  // One guard bit above the accumulator exposes two's-complement overflow.
  assign w_sum_i_ext = {r_acc_i[ACC_WIDTH-1], r_acc_i}
                     + {{c_ext{sample_i[SAMPLE_WIDTH-1]}}, sample_i};
  assign w_sum_q_ext = {r_acc_q[ACC_WIDTH-1], r_acc_q}
                     + {{c_ext{sample_q[SAMPLE_WIDTH-1]}}, sample_q};
  assign w_ovf_i     = w_sum_i_ext[ACC_WIDTH] ^ w_sum_i_ext[ACC_WIDTH-1];
  assign w_ovf_q     = w_sum_q_ext[ACC_WIDTH] ^ w_sum_q_ext[ACC_WIDTH-1];
  assign w_acc_i_next = w_ovf_i ? (w_sum_i_ext[ACC_WIDTH] ? c_acc_min : c_acc_max)
                                : w_sum_i_ext[ACC_WIDTH-1:0];
  assign w_acc_q_next = w_ovf_q ? (w_sum_q_ext[ACC_WIDTH] ? c_acc_min : c_acc_max)
                                : w_sum_q_ext[ACC_WIDTH-1:0];
  assign w_cnt_next  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_accept    = r_result_valid & result_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_step_idx     <= '0;
      r_window_step  <= '0;
      r_acc_i        <= '0;
      r_acc_q        <= '0;
      r_cnt          <= '0;
      r_sat_flag     <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_step  <= '0;
      r_result_sum_i <= '0;
      r_result_sum_q <= '0;
      r_result_count <= '0;
      r_result_sat   <= 1'b0;
      r_drop_count   <= '0;
    end else if (rx_reset) begin
      r_state        <= ST_IDLE;
      r_step_idx     <= '0;
      r_acc_i        <= '0;
      r_acc_q        <= '0;
      r_cnt          <= '0;
      r_sat_flag     <= 1'b0;
      r_result_valid <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      if (rx_next) begin
        r_step_idx <= r_step_idx + 1'b1;
      end
      if (w_accept) begin
        r_result_valid <= 1'b0;
      end

      if (rx_record) begin
        if (r_state == ST_IDLE) begin
          r_state       <= ST_ACCUM;
          r_window_step <= r_step_idx;
        end
        // Accumulators sit at zero in IDLE, so the entry-cycle sample adds cleanly.
        if (sample_strobe) begin
          r_acc_i    <= w_acc_i_next;
          r_acc_q    <= w_acc_q_next;
          r_cnt      <= w_cnt_next;
          r_sat_flag <= r_sat_flag | w_ovf_i | w_ovf_q;
        end
      end else if (r_state == ST_ACCUM) begin
        r_state    <= ST_IDLE;
        r_acc_i    <= '0;
        r_acc_q    <= '0;
        r_cnt      <= '0;
        r_sat_flag <= 1'b0;
        if (!r_result_valid || w_accept) begin
          r_result_valid <= 1'b1;
          r_result_step  <= r_window_step;
          r_result_sum_i <= r_acc_i;
          r_result_sum_q <= r_acc_q;
          r_result_count <= r_cnt;
          r_result_sat   <= r_sat_flag;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign result_valid = r_result_valid;
  assign result_step  = r_result_step;
  assign result_sum_i = r_result_sum_i;
  assign result_sum_q = r_result_sum_q;
  assign result_count = r_result_count;
  assign result_sat   = r_result_sat;
  assign drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_fast_square_step_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fast_square_step_accumulator: directed vectors, 18-bit accumulator.   |
// |                                                      Rev 1.0             |
// +--------------------------------------------------------------------------+
module tb_fast_square_step_accumulator;

  localparam int SW  = 16;
  localparam int AW  = 18;
  localparam int STW = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [SW-1:0]  sample_i;
  logic [SW-1:0]  sample_q;
  logic           sample_strobe;
  logic           rx_record;
  logic           rx_next;
  logic           rx_reset;
  logic           result_valid;
  logic           result_ready;
  logic [STW-1:0] result_step;
  logic [AW-1:0]  result_sum_i;
  logic [AW-1:0]  result_sum_q;
  logic [15:0]    result_count;
  logic           result_sat;
  logic [7:0]     drop_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fast_square_step_accumulator #(
    .SAMPLE_WIDTH (SW),
    .ACC_WIDTH    (AW),
    .STEP_WIDTH   (STW)
  ) u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sample_i      (sample_i),
    .sample_q      (sample_q),
    .sample_strobe (sample_strobe),
    .rx_record     (rx_record),
    .rx_next       (rx_next),
    .rx_reset      (rx_reset),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_step   (result_step),
    .result_sum_i  (result_sum_i),
    .result_sum_q  (result_sum_q),
    .result_count  (result_count),
    .result_sat    (result_sat),
    .drop_count    (drop_count)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rec(input logic stb, input int si, input int sq, input logic nxt);
    rx_record     = 1'b1;
    sample_strobe = stb;
    sample_i      = SW'(si);
    sample_q      = SW'(sq);
    rx_next       = nxt;
    tick();
    rx_next       = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic end_window();
    rx_record     = 1'b0;
    sample_strobe = 1'b0;
    tick();
  endtask

  task automatic check_result(input string tag, input int step, input int si,
                              input int sq, input int cnt, input int sat);
    check({tag, "_valid"}, longint'(result_valid), 1);
    check({tag, "_step"},  longint'(result_step), step);
    check({tag, "_sum_i"}, longint'($signed(result_sum_i)), si);
    check({tag, "_sum_q"}, longint'($signed(result_sum_q)), sq);
    check({tag, "_count"}, longint'(result_count), cnt);
    check({tag, "_sat"},   longint'(result_sat), sat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, longint'(result_valid), 0);
    check({tag, "_step"},  longint'(result_step), 0);
    check({tag, "_sum_i"}, longint'($signed(result_sum_i)), 0);
    check({tag, "_sum_q"}, longint'($signed(result_sum_q)), 0);
    check({tag, "_count"}, longint'(result_count), 0);
    check({tag, "_sat"},   longint'(result_sat), 0);
    check({tag, "_drop"},  longint'(drop_count), 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    sample_i      = '0;
    sample_q      = '0;
    sample_strobe = 1'b0;
    rx_record     = 1'b0;
    rx_next       = 1'b0;
    rx_reset      = 1'b0;
    result_ready  = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Stray strobe while idle must not leak into the next window.
    sample_strobe = 1'b1;
    sample_i      = SW'(1000);
    tick();
    sample_strobe = 1'b0;

    rec(1'b1, 100, -1, 1'b0);
    rec(1'b1, -20, -1, 1'b0);
    rec(1'b0, 0, 0, 1'b0);
    rec(1'b1, 5, -1, 1'b0);
    rec(1'b0, 0, 0, 1'b0);
    rec(1'b1, 15, -1, 1'b0);
    check("basic_n0_valid", longint'(result_valid), 0);
    end_window();
    check_result("basic", 0, 100, -4, 4, 0);
    tick();
    check("basic_accepted", longint'(result_valid), 0);

    for (int k = 0; k < 10; k++) rec(1'b1, 32767, 0, 1'b0);
    end_window();
    check_result("sat", 0, 131071, 0, 10, 1);
    tick();

    result_ready = 1'b0;
    rec(1'b1, 7, 0, 1'b0);
    end_window();
    check("bp_first_sum", longint'($signed(result_sum_i)), 7);
    tick();
    rec(1'b1, 9, 0, 1'b0);
    end_window();
    check("bp_held_valid", longint'(result_valid), 1);
    check("bp_held_sum", longint'($signed(result_sum_i)), 7);
    check("bp_drop", longint'(drop_count), 1);
    result_ready = 1'b1;
    tick();
    check("bp_accepted", longint'(result_valid), 0);

    for (int k = 0; k < 3; k++) begin
      rec(1'b1, k + 1, 0, 1'b0);
      rec(1'b0, 0, 0, 1'b1);
      end_window();
      check_result($sformatf("step%0d", k), k, k + 1, 0, 1, 0);
      tick();
    end
    rec(1'b0, 0, 0, 1'b0);
    end_window();
    check_result("zero_win", 3, 0, 0, 0, 0);
    tick();
    rx_next = 1'b1;
    for (int k = 0; k < 253; k++) tick();
    rx_next = 1'b0;
    rec(1'b1, 4, 0, 1'b0);
    end_window();
    check_result("wrap", 0, 4, 0, 1, 0);
    check("wrap_drop", longint'(drop_count), 1);
    tick();

    rx_next = 1'b1;
    tick();
    tick();
    rx_next      = 1'b0;
    result_ready = 1'b0;
    rec(1'b1, 3, 0, 1'b0);
    end_window();
    check("rr_pending", longint'(result_valid), 1);
    rec(1'b1, 5, 0, 1'b0);
    rec(1'b1, 5, 0, 1'b0);
    rx_reset      = 1'b1;
    rx_record     = 1'b1;
    sample_strobe = 1'b1;
    tick();
    tick();
    tick();
    check("rr_valid", longint'(result_valid), 0);
    check("rr_drop", longint'(drop_count), 0);
    rx_reset      = 1'b0;
    rx_record     = 1'b0;
    sample_strobe = 1'b0;
    tick();
    tick();
    check("rr_no_publish", longint'(result_valid), 0);
    result_ready = 1'b1;
    rec(1'b1, 2, 0, 1'b0);
    end_window();
    check_result("rr_next", 0, 2, 0, 1, 0);
    tick();

    result_ready = 1'b0;
    rec(1'b1, 11, 0, 1'b0);
    end_window();
    rec(1'b1, 1, 0, 1'b0);
    end_window();
    check("ar_pre_drop", longint'(drop_count), 1);
    rec(1'b1, 6, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async");
    tick();
    tick();
    tick();
    rx_record = 1'b0;
    reset_n   = 1'b1;
    tick();
    tick();
    check("ar_no_result", longint'(result_valid), 0);
    result_ready = 1'b1;
    rec(1'b1, 8, 0, 1'b0);
    end_window();
    check_result("ar_next", 0, 8, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
